// File: rtl/gate_logic_pkg.sv
// Shared opcode definitions for the registered bitwise logic pipeline.
package gate_logic_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NAND = 3'b011,
        OP_NOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_PASSX = 3'b110,
        OP_NOTX = 3'b111
    } op_e;

endpackage

// File: rtl/gate_logic_unit.sv
// Combinational WIDTH-bit bitwise operator selected by a 3-bit opcode.
module gate_logic_unit
    import gate_logic_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] r
);

    always_comb begin
        r = '0;
        case (op_e'(op))
            OP_AND:   r = x & b;
            OP_OR:    r = x | b;
            OP_XOR:   r = x ^ b;
            OP_NAND:  r = ~(x & b);
            OP_NOR:   r = ~(x | b);
            OP_XNOR:  r = ~(x ^ b);
            OP_PASSX: r = x;
            OP_NOTX:  r = ~x;
        endcase
    end

endmodule

// File: rtl/gate_logic_pipe.sv
// One elastic valid/ready stage around gate_logic_unit, with accumulator,
// registered zero/parity flags and a completed-transaction counter.
module gate_logic_pipe
    import gate_logic_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic [OP_W-1:0]  in_op,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_par,
    output logic [WIDTH-1:0] acc_q,
    output logic [CNT_W-1:0] txn_cnt
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             zero_q, zero_d;
    logic             par_q, par_d;
    logic [WIDTH-1:0] acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH-1:0] unit_r;
    logic [WIDTH-1:0] result;

    assign in_ready  = !valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign operand_b = acc_en ? acc_q : in_y;

    gate_logic_unit #(.WIDTH(WIDTH)) u_unit (
        .x  (in_x),
        .b  (operand_b),
        .op (in_op),
        .r  (unit_r)
    );

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        zero_d  = zero_q;
        par_d   = par_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;

        // Seeding the accumulator bypasses the opcode: the beat yields in_x.
        result = (acc_clr && acc_en) ? in_x : unit_r;

        if (accept) begin
            valid_d = 1'b1;
            data_d  = result;
            zero_d  = (result == '0);
            par_d   = ^result;
            if (acc_en) begin
                acc_d = result;
            end else if (acc_clr) begin
                acc_d = '0;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        if (valid_q && out_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            zero_q  <= 1'b0;
            par_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
            par_q   <= par_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_zero  = zero_q;
    assign out_par   = par_q;
    assign txn_cnt   = cnt_q;

endmodule

// File: tb/tb_gate_logic_pipe.sv
// Directed self-checking bench for gate_logic_pipe (WIDTH=4, CNT_W=8).
module tb_gate_logic_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_x;
    logic [3:0] in_y;
    logic [2:0] in_op;
    logic       acc_en;
    logic       acc_clr;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       out_zero;
    logic       out_par;
    logic [3:0] acc_q;
    logic [7:0] txn_cnt;

    int unsigned total;
    int unsigned bad;

    gate_logic_pipe #(.WIDTH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_op     (in_op),
        .acc_en    (acc_en),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_par   (out_par),
        .acc_q     (acc_q),
        .txn_cnt   (txn_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge, then settle before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [3:0] x, input logic [3:0] y, input logic [2:0] op,
                        input logic en, input logic clr);
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        in_op    = op;
        acc_en   = en;
        acc_clr  = clr;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        acc_en   = 1'b0;
        acc_clr  = 1'b0;
    endtask

    logic [3:0] exp_ops [8];

    initial begin
        total = 0;
        bad   = 0;
        exp_ops = '{4'b0001, 4'b0111, 4'b0110, 4'b1110, 4'b1000, 4'b1001, 4'b0011, 4'b1100};

        rst = 1'b1;
        out_ready = 1'b0;
        in_x = '0; in_y = '0; in_op = '0;
        idle();
        step();
        step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_zero",  32'(out_zero),  32'd0);
        chk("rst_par",   32'(out_par),   32'd0);
        chk("rst_acc",   32'(acc_q),     32'd0);
        chk("rst_cnt",   32'(txn_cnt),   32'd0);
        rst = 1'b0;

        // 1: all opcodes back to back
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            beat(4'b0011, 4'b0101, 3'(i), 1'b0, 1'b0);
            chk("t1_in_ready", 32'(in_ready), 32'd1);
            step();
            chk($sformatf("t1_op%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("t1_op%0d_data", i), 32'(out_data), 32'(exp_ops[i]));
            chk($sformatf("t1_op%0d_cnt", i), 32'(txn_cnt), 32'(i));
        end
        idle();
        step();
        chk("t1_drain_valid", 32'(out_valid), 32'd0);
        chk("t1_drain_hold",  32'(out_data),  32'b1100);
        chk("t1_cnt",         32'(txn_cnt),   32'd8);

        // 2: backpressure
        out_ready = 1'b0;
        beat(4'b1001, 4'b0000, 3'b110, 1'b0, 1'b0);
        step();
        chk("t2_a_valid", 32'(out_valid), 32'd1);
        chk("t2_a_data",  32'(out_data),  32'b1001);
        beat(4'b0110, 4'b0000, 3'b110, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("t2_stall_ready", 32'(in_ready), 32'd0);
            step();
            chk("t2_stall_data",  32'(out_data),  32'b1001);
            chk("t2_stall_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("t2_release_ready", 32'(in_ready), 32'd1);
        step();
        chk("t2_b_data",  32'(out_data),  32'b0110);
        chk("t2_b_valid", 32'(out_valid), 32'd1);
        chk("t2_b_cnt",   32'(txn_cnt),   32'd9);
        idle();
        step();
        chk("t2_drain_valid", 32'(out_valid), 32'd0);
        chk("t2_cnt",         32'(txn_cnt),   32'd10);

        // 3: XOR accumulate with seed
        beat(4'b0001, 4'b1111, 3'b010, 1'b1, 1'b1);
        step();
        chk("t3_seed_data", 32'(out_data), 32'b0001);
        chk("t3_seed_acc",  32'(acc_q),    32'b0001);
        beat(4'b0010, 4'b1111, 3'b010, 1'b1, 1'b0);
        step();
        chk("t3_b2_data", 32'(out_data), 32'b0011);
        beat(4'b0100, 4'b1111, 3'b010, 1'b1, 1'b0);
        step();
        chk("t3_b3_data", 32'(out_data), 32'b0111);
        chk("t3_acc",     32'(acc_q),    32'b0111);
        chk("t3_zero",    32'(out_zero), 32'd0);
        chk("t3_par",     32'(out_par),  32'd1);
        // acc controls must be ignored without an accepted beat
        in_valid = 1'b0;
        acc_en   = 1'b1;
        acc_clr  = 1'b1;
        step();
        chk("t3_idle_acc", 32'(acc_q),    32'b0111);
        chk("t3_cnt",      32'(txn_cnt),  32'd13);
        idle();

        // 4: AND giving zero; acc_clr with acc_en=0 would clear, so leave it off
        beat(4'b1010, 4'b0101, 3'b000, 1'b0, 1'b0);
        step();
        chk("t4_data", 32'(out_data), 32'd0);
        chk("t4_zero", 32'(out_zero), 32'd1);
        chk("t4_par",  32'(out_par),  32'd0);
        chk("t4_acc",  32'(acc_q),    32'b0111);
        idle();
        step();

        // 5: reset while stalled
        out_ready = 1'b0;
        beat(4'b1100, 4'b0000, 3'b110, 1'b0, 1'b0);
        step();
        chk("t5_pre_valid", 32'(out_valid), 32'd1);
        chk("t5_pre_ready", 32'(in_ready),  32'd0);
        rst = 1'b1;
        beat(4'b1111, 4'b1111, 3'b001, 1'b1, 1'b0);
        step();
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_data",  32'(out_data),  32'd0);
        chk("t5_zero",  32'(out_zero),  32'd0);
        chk("t5_par",   32'(out_par),   32'd0);
        chk("t5_acc",   32'(acc_q),     32'd0);
        chk("t5_cnt",   32'(txn_cnt),   32'd0);
        chk("t5_ready", 32'(in_ready),  32'd1);
        rst = 1'b0;
        idle();

        // 6: counter wrap
        out_ready = 1'b1;
        beat(4'b0101, 4'b0011, 3'b010, 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) begin
            step();
        end
        chk("t6_cnt_max", 32'(txn_cnt), 32'd255);
        idle();
        step();
        chk("t6_cnt_wrap", 32'(txn_cnt),   32'd0);
        chk("t6_valid",    32'(out_valid), 32'd0);
        chk("t6_data",     32'(out_data),  32'b0110);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
